descriptor_rr_arbiter: RTL and testbench

//   Round-robin arbiter that shares the network-transmit input-queue descriptor FIFO among

---
 rtl/descriptor_rr_arbiter.sv | 121 ++++++++++++
 tb/tb_descriptor_rr_arbiter.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/descriptor_rr_arbiter.sv
// Round-robin arbiter in front of the transmit descriptor FIFO write port.
// One registered grant per request; the granted port must release before the next arbitration.
module descriptor_rr_arbiter #(
    parameter int PORT_NUM    = 4,
    parameter int FIFO_AW     = 8,
    parameter int FULL_THRESH = 250
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [PORT_NUM*48-1:0] iv_tsntag,
    input  logic [PORT_NUM*3-1:0]  iv_pkt_type,
    input  logic [PORT_NUM*9-1:0]  iv_bufid,
    input  logic [PORT_NUM-1:0]    i_descriptor_wr,
    output logic [PORT_NUM-1:0]    ov_descriptor_ack,
    input  logic [FIFO_AW-1:0]     iv_fifo_usedw,
    output logic [56:0]            ov_fifo_wdata,
    output logic [2:0]             ov_pkt_type,
    output logic                   o_fifo_wr
);

    localparam int                 PTR_W     = (PORT_NUM > 2) ? $clog2(PORT_NUM) : 1;
    localparam logic [FIFO_AW-1:0] THRESH    = FIFO_AW'(FULL_THRESH);
    localparam logic [PTR_W-1:0]   LAST_PORT = PTR_W'(PORT_NUM - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_WAIT_REL = 2'b01
    } state_e;

    state_e                state_q, state_d;
    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]      gnt_idx_q, gnt_idx_d;
    logic [PORT_NUM-1:0]   ack_q, ack_d;
    logic                  fifo_wr_q, fifo_wr_d;
    logic [56:0]           wdata_q, wdata_d;
    logic [2:0]            pkt_type_q, pkt_type_d;

    logic [PTR_W-1:0]      pick_s;
    logic [PTR_W-1:0]      cand_s;
    logic                  found_s;
    logic                  eligible_s;
    int                    scan_sum_s;

    // Rotating scan from rr_ptr; wrap is explicit so PORT_NUM need not be a power of two.
    always_comb begin
        found_s    = 1'b0;
        pick_s     = '0;
        cand_s     = '0;
        scan_sum_s = 0;
        for (int i = 0; i < PORT_NUM; i++) begin
            scan_sum_s = int'(rr_ptr_q) + i;
            cand_s     = PTR_W'((scan_sum_s >= PORT_NUM) ? (scan_sum_s - PORT_NUM) : scan_sum_s);
            pick_s     = (!found_s && i_descriptor_wr[cand_s]) ? cand_s : pick_s;
            found_s    = found_s | i_descriptor_wr[cand_s];
        end
        eligible_s = found_s && (iv_fifo_usedw < THRESH);
    end

    // Next-state and next-output logic; every strobe is a single cycle.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        gnt_idx_d  = gnt_idx_q;
        ack_d      = '0;
        fifo_wr_d  = 1'b0;
        wdata_d    = '0;
        pkt_type_d = '0;
        case (state_q)
            ST_IDLE: begin
                if (eligible_s) begin
                    fifo_wr_d  = 1'b1;
                    ack_d      = {{(PORT_NUM-1){1'b0}}, 1'b1} << pick_s;
                    wdata_d    = {iv_tsntag[48*int'(pick_s) +: 48], iv_bufid[9*int'(pick_s) +: 9]};
                    pkt_type_d = iv_pkt_type[3*int'(pick_s) +: 3];
                    gnt_idx_d  = pick_s;
                    rr_ptr_d   = (pick_s == LAST_PORT) ? '0 : (pick_s + 1'b1);
                    state_d    = ST_WAIT_REL;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_WAIT_REL: begin
                if (!i_descriptor_wr[gnt_idx_q]) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_REL;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, pointer and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            gnt_idx_q  <= '0;
            ack_q      <= '0;
            fifo_wr_q  <= 1'b0;
            wdata_q    <= '0;
            pkt_type_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_idx_q  <= gnt_idx_d;
            ack_q      <= ack_d;
            fifo_wr_q  <= fifo_wr_d;
            wdata_q    <= wdata_d;
            pkt_type_q <= pkt_type_d;
        end
    end

    assign ov_descriptor_ack = ack_q;
    assign o_fifo_wr         = fifo_wr_q;
    assign ov_fifo_wdata     = wdata_q;
    assign ov_pkt_type       = pkt_type_q;

endmodule

// File: tb/tb_descriptor_rr_arbiter.sv
// Bench for descriptor_rr_arbiter: directed steps then random traffic against a queue-free
// behavioural model (busy port + next-start pointer, modulo arithmetic).
module tb_descriptor_rr_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int TH = 250;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [N*48-1:0] tsntag;
    logic [N*3-1:0]  pkt_type_in;
    logic [N*9-1:0]  bufid;
    logic [N-1:0]    wr;
    logic [N-1:0]    ack;
    logic [AW-1:0]   usedw;
    logic [56:0]     wdata;
    logic [2:0]      ptype;
    logic            fwr;

    descriptor_rr_arbiter #(.PORT_NUM(N), .FIFO_AW(AW), .FULL_THRESH(TH)) dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .iv_tsntag         (tsntag),
        .iv_pkt_type       (pkt_type_in),
        .iv_bufid          (bufid),
        .i_descriptor_wr   (wr),
        .ov_descriptor_ack (ack),
        .iv_fifo_usedw     (usedw),
        .ov_fifo_wdata     (wdata),
        .ov_pkt_type       (ptype),
        .o_fifo_wr         (fwr)
    );

    always #5 clk = ~clk;

    logic [47:0] t_tag [N];
    logic [8:0]  t_buf [N];
    logic [2:0]  t_typ [N];

    int n_vec = 0;
    int n_err = 0;

    // reference model
    int          m_busy;
    int          m_ptr;
    logic [N-1:0] e_ack;
    logic        e_wr;
    logic [56:0] e_wdata;
    logic [2:0]  e_type;

    // bookkeeping
    int cyc = 0;
    int tot_wr = 0;
    int tot_ack = 0;
    bit got [N];
    int wait_g [N];
    int gq[$];
    int tq[$];

    // requester driver
    bit drv_on = 1'b0;
    int stage [N];
    int hold [N];
    int low [N];
    int cfg_extra = 0;
    int cfg_low = 0;
    int cfg_raise = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pack();
        for (int p = 0; p < N; p++) begin
            tsntag[48*p +: 48]    = t_tag[p];
            bufid[9*p +: 9]       = t_buf[p];
            pkt_type_in[3*p +: 3] = t_typ[p];
        end
    endtask

    task automatic new_data(input int p);
        t_tag[p] = 48'({$urandom(), $urandom()});
        t_buf[p] = 9'($urandom());
        t_typ[p] = 3'($urandom());
    endtask

    task automatic model_reset();
        m_busy = -1;
        m_ptr  = 0;
        for (int p = 0; p < N; p++) begin
            got[p]    = 1'b0;
            wait_g[p] = 0;
            stage[p]  = 0;
        end
    endtask

    // What the arbiter must present after the coming edge, from the rules alone.
    task automatic model_edge();
        int k;
        e_ack = '0; e_wr = 1'b0; e_wdata = '0; e_type = '0;
        if (m_busy < 0) begin
            if (wr != '0 && int'(usedw) < TH) begin
                k = -1;
                for (int i = 0; i < N; i++)
                    if (k < 0 && wr[(m_ptr + i) % N]) k = (m_ptr + i) % N;
                e_ack[k] = 1'b1;
                e_wr     = 1'b1;
                e_wdata  = {t_tag[k], t_buf[k]};
                e_type   = t_typ[k];
                m_busy   = k;
                m_ptr    = (k + 1) % N;
            end
        end else if (!wr[m_busy]) begin
            m_busy = -1;
        end
    endtask

    task automatic cycle();
        bit pend [N];
        pack();
        for (int p = 0; p < N; p++) begin
            if (!wr[p]) got[p] = 1'b0;
            pend[p] = wr[p] && !got[p];
        end
        model_edge();
        @(posedge clk);
        #1;
        cyc++;
        chk("ack", 64'(ack), 64'(e_ack));
        chk("fifo_wr", 64'(fwr), 64'(e_wr));
        chk("wdata", 64'(wdata), 64'(e_wdata));
        chk("pkt_type", 64'(ptype), 64'(e_type));
        chk("wr_eq_or_ack", 64'(fwr), 64'(|ack));
        chk("onehot0", 64'($onehot0(ack)), 64'd1);
        if (fwr) tot_wr++;
        tot_ack += $countones(ack);
        for (int p = 0; p < N; p++) begin
            if (ack[p]) begin
                got[p] = 1'b1;
                wait_g[p] = 0;
                gq.push_back(p);
                tq.push_back(cyc);
                if (drv_on) begin
                    stage[p] = 1;
                    hold[p]  = 1 + $urandom_range(cfg_extra, 0);
                end
            end else if (fwr && pend[p]) begin
                wait_g[p]++;
                chk("no_starve", 64'(wait_g[p] <= N - 1), 64'd1);
            end
        end
    endtask

    task automatic drive();
        for (int p = 0; p < N; p++) begin
            case (stage[p])
                1: if (hold[p] > 0) hold[p]--;
                   else begin wr[p] = 1'b0; stage[p] = 2; low[p] = $urandom_range(cfg_low, 0); end
                2: if (low[p] > 0) low[p]--; else stage[p] = 0;
                default: ;
            endcase
            if (stage[p] == 0 && !wr[p] && $urandom_range(99, 0) < cfg_raise) begin
                new_data(p);
                wr[p] = 1'b1;
            end
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int wr0;
        int exp2 [6] = '{0, 1, 2, 3, 0, 1};

        rst_n = 1'b0;
        wr = '0; usedw = '0;
        for (int p = 0; p < N; p++) begin t_tag[p] = '0; t_buf[p] = '0; t_typ[p] = '0; end
        pack();
        model_reset();
        #12;
        chk("rst_ack", 64'(ack), 64'd0);
        chk("rst_wr", 64'(fwr), 64'd0);
        chk("rst_wdata", 64'(wdata), 64'd0);
        chk("rst_type", 64'(ptype), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: single held request, exactly one write
        t_tag[2] = 48'hA5; t_buf[2] = 9'h1F; t_typ[2] = 3'd4;
        wr = 4'b0100;
        wr0 = tot_wr;
        cycle();
        chk("t1_wdata", 64'(wdata), 64'h14A1F);
        chk("t1_ack", 64'(ack), 64'b0100);
        chk("t1_type", 64'(ptype), 64'd4);
        repeat (9) cycle();
        chk("t1_single_write", 64'(tot_wr - wr0), 64'd1);
        wr = '0;
        repeat (2) cycle();

        // 2: all ports busy, each drops for one cycle after ack
        do_reset();
        gq.delete(); tq.delete();
        for (int p = 0; p < N; p++) new_data(p);
        wr = 4'b1111;
        drv_on = 1'b1; cfg_extra = 0; cfg_low = 0; cfg_raise = 100;
        for (int b = 0; b < 40 && gq.size() < 6; b++) begin
            cycle();
            drive();
        end
        chk("t2_count", 64'(gq.size() >= 6), 64'd1);
        for (int i = 0; i < 6 && i < gq.size(); i++) chk("t2_order", 64'(gq[i]), 64'(exp2[i]));
        for (int i = 1; i < 6 && i < gq.size(); i++) chk("t2_gap", 64'(tq[i] - tq[i-1]), 64'd3);
        drv_on = 1'b0;
        wr = '0;
        for (int p = 0; p < N; p++) stage[p] = 0;
        repeat (3) cycle();

        // 3: threshold hold-off, then release at 249
        usedw = 8'd250;
        new_data(1);
        wr = 4'b0010;
        repeat (20) begin
            cycle();
            chk("t3_blocked", 64'(fwr), 64'd0);
        end
        usedw = 8'd249;
        cycle();
        chk("t3_grant", 64'(ack), 64'b0010);
        wr = '0; usedw = '0;
        repeat (2) cycle();

        // 4: wrap-around from rr_ptr=3
        new_data(2);
        wr = 4'b0100;
        cycle();
        chk("t4_p2", 64'(ack), 64'b0100);
        wr = '0;
        cycle();
        new_data(0); new_data(3);
        wr = 4'b1001;
        cycle();
        chk("t4_p3_first", 64'(ack), 64'b1000);
        wr = 4'b0001;
        cycle();
        cycle();
        chk("t4_p0_second", 64'(ack), 64'b0001);
        wr = '0;
        repeat (2) cycle();

        // 5: asynchronous reset while in WAIT_REL
        new_data(1);
        wr = 4'b0010;
        cycle();
        chk("t5_grant", 64'(ack), 64'b0010);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_rst_ack", 64'(ack), 64'd0);
        chk("t5_rst_wr", 64'(fwr), 64'd0);
        chk("t5_rst_wdata", 64'(wdata), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle();
        chk("t5_regrant", 64'(ack), 64'b0010);
        wr = '0;
        repeat (2) cycle();

        // 6: random traffic with random fill level
        drv_on = 1'b1; cfg_extra = 2; cfg_low = 3; cfg_raise = 40;
        tot_wr = 0; tot_ack = 0;
        for (int p = 0; p < N; p++) stage[p] = 0;
        for (int c = 0; c < 10000; c++) begin
            usedw = ($urandom_range(3, 0) == 0) ? 8'($urandom_range(255, 244)) : 8'($urandom_range(243, 0));
            drive();
            cycle();
        end
        drv_on = 1'b0;
        wr = '0; usedw = '0;
        repeat (3) cycle();
        chk("t6_wr_vs_ack", 64'(tot_wr), 64'(tot_ack));
        chk("t6_traffic", 64'(tot_wr > 100), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
